// File: rtl/d_victim_cache_ctrl.sv
// Victim cache sequencer: one L1 miss at a time through lookup, optional dirty-victim writeback,
// a single array write (swap, invalidate or insert) and a one-cycle response pulse.
// Handshakes: a request transfers on req_valid_i && req_ready_o; a writeback transfers on
// mem_wb_valid_o && mem_wb_ready_i, and mem_wb_tag_o stays stable while valid waits for ready.
module d_victim_cache_ctrl #(
  parameter int WAYS_VC      = 8,
  parameter int INDEX_WAY_VC = 3,
  parameter int TAG_W        = 28
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [TAG_W-1:0]        req_tag_i,
  input  logic                    evict_valid_i,
  input  logic                    evict_dirty_i,
  input  logic [TAG_W-1:0]        evict_tag_i,
  output logic                    resp_valid_o,
  output logic                    resp_hit_o,
  output logic                    resp_dirty_o,
  output logic [TAG_W-1:0]        lookup_tag_o,
  input  logic                    tag_hit_i,
  input  logic [INDEX_WAY_VC-1:0] tag_hit_way_i,
  input  logic [WAYS_VC-1:0]      tag_valid_vec_i,
  input  logic                    rd_dirty_i,
  output logic                    tag_we_o,
  output logic [INDEX_WAY_VC-1:0] tag_way_o,
  output logic                    wr_valid_o,
  output logic                    wr_dirty_o,
  output logic [TAG_W-1:0]        wr_tag_o,
  output logic                    mem_wb_valid_o,
  input  logic                    mem_wb_ready_i,
  output logic [TAG_W-1:0]        mem_wb_tag_o,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WB     = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [INDEX_WAY_VC-1:0] rr_q, rr_d;
  logic [TAG_W-1:0]        req_tag_q, req_tag_d;
  logic                    ev_valid_q, ev_valid_d;
  logic                    ev_dirty_q, ev_dirty_d;
  logic [TAG_W-1:0]        ev_tag_q, ev_tag_d;
  logic [INDEX_WAY_VC-1:0] tgt_q, tgt_d;
  logic                    full_q, full_d;
  logic                    hit_q, hit_d;
  logic                    rdirty_q, rdirty_d;
  logic [TAG_W-1:0]        wb_tag_q, wb_tag_d;
  logic                    wr_valid_q, wr_valid_d;
  logic                    wr_dirty_q, wr_dirty_d;
  logic [TAG_W-1:0]        wr_tag_q, wr_tag_d;

  // The array offers no tag read port, so the victim address for writeback comes from a
  // copy of every tag this block has written; like the array itself it is not cleared by reset.
  logic [TAG_W-1:0]        shadow_q [WAYS_VC];

  logic                    free_found;
  logic [INDEX_WAY_VC-1:0] free_way;

  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int i = WAYS_VC - 1; i >= 0; i--) begin
      if (!tag_valid_vec_i[i]) begin
        free_found = 1'b1;
        free_way   = INDEX_WAY_VC'(i);
      end
    end
  end

  // In LOOKUP the read port points at the hit way (so rd_dirty_i is the hit line's dirty bit)
  // or at the round-robin candidate; afterwards it holds the latched target.
  assign tag_way_o    = (state_q == S_LOOKUP) ? (tag_hit_i ? tag_hit_way_i : rr_q) : tgt_q;
  assign lookup_tag_o = req_tag_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    req_tag_d  = req_tag_q;
    ev_valid_d = ev_valid_q;
    ev_dirty_d = ev_dirty_q;
    ev_tag_d   = ev_tag_q;
    tgt_d      = tgt_q;
    full_d     = full_q;
    hit_d      = hit_q;
    rdirty_d   = rdirty_q;
    wb_tag_d   = wb_tag_q;
    wr_valid_d = wr_valid_q;
    wr_dirty_d = wr_dirty_q;
    wr_tag_d   = wr_tag_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          req_tag_d  = req_tag_i;
          ev_valid_d = evict_valid_i;
          ev_dirty_d = evict_dirty_i;
          ev_tag_d   = evict_tag_i;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (tag_hit_i) begin
          tgt_d      = tag_hit_way_i;
          hit_d      = 1'b1;
          full_d     = 1'b0;
          rdirty_d   = rd_dirty_i;
          wr_valid_d = ev_valid_q;
          wr_dirty_d = ev_valid_q & ev_dirty_q;
          wr_tag_d   = ev_tag_q;
          state_d    = S_WRITE;
        end else if (!ev_valid_q) begin
          hit_d    = 1'b0;
          full_d   = 1'b0;
          rdirty_d = 1'b0;
          state_d  = S_RESP;
        end else begin
          hit_d      = 1'b0;
          rdirty_d   = 1'b0;
          wr_valid_d = 1'b1;
          wr_dirty_d = ev_dirty_q;
          wr_tag_d   = ev_tag_q;
          if (free_found) begin
            tgt_d   = free_way;
            full_d  = 1'b0;
            state_d = S_WRITE;
          end else begin
            tgt_d    = rr_q;
            full_d   = 1'b1;
            wb_tag_d = shadow_q[rr_q];
            state_d  = rd_dirty_i ? S_WB : S_WRITE;
          end
        end
      end
      S_WB: begin
        if (mem_wb_ready_i) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (full_q && !hit_q) rr_d = rr_q + INDEX_WAY_VC'(1);
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      req_tag_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_dirty_q <= 1'b0;
      ev_tag_q   <= '0;
      tgt_q      <= '0;
      full_q     <= 1'b0;
      hit_q      <= 1'b0;
      rdirty_q   <= 1'b0;
      wb_tag_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_dirty_q <= 1'b0;
      wr_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      req_tag_q  <= req_tag_d;
      ev_valid_q <= ev_valid_d;
      ev_dirty_q <= ev_dirty_d;
      ev_tag_q   <= ev_tag_d;
      tgt_q      <= tgt_d;
      full_q     <= full_d;
      hit_q      <= hit_d;
      rdirty_q   <= rdirty_d;
      wb_tag_q   <= wb_tag_d;
      wr_valid_q <= wr_valid_d;
      wr_dirty_q <= wr_dirty_d;
      wr_tag_q   <= wr_tag_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_WRITE) shadow_q[tgt_q] <= wr_tag_q;
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign resp_valid_o   = (state_q == S_RESP);
  assign resp_hit_o     = (state_q == S_RESP) & hit_q;
  assign resp_dirty_o   = (state_q == S_RESP) & rdirty_q;
  assign tag_we_o       = (state_q == S_WRITE);
  assign wr_valid_o     = wr_valid_q;
  assign wr_dirty_o     = wr_dirty_q;
  assign wr_tag_o       = wr_tag_q;
  assign mem_wb_valid_o = (state_q == S_WB);
  assign mem_wb_tag_o   = wb_tag_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_d_victim_cache_ctrl.sv
// Bench for d_victim_cache_ctrl: a behavioural victim-cache model predicts responses, array writes
// and writebacks; a negedge monitor pops and compares them while also playing tag array and memory.
module tb_d_victim_cache_ctrl;
  localparam int TW = 28;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [TW-1:0] req_tag_i = '0;
  logic          evict_valid_i = 1'b0;
  logic          evict_dirty_i = 1'b0;
  logic [TW-1:0] evict_tag_i = '0;
  logic          resp_valid_o, resp_hit_o, resp_dirty_o;
  logic [TW-1:0] lookup_tag_o;
  logic          tag_hit_i;
  logic [2:0]    tag_hit_way_i;
  logic [7:0]    tag_valid_vec_i;
  logic          rd_dirty_i;
  logic          tag_we_o;
  logic [2:0]    tag_way_o;
  logic          wr_valid_o, wr_dirty_o;
  logic [TW-1:0] wr_tag_o;
  logic          mem_wb_valid_o;
  logic          mem_wb_ready_i = 1'b0;
  logic [TW-1:0] mem_wb_tag_o;
  logic [2:0]    dbg_state_o;

  d_victim_cache_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_tag_i(req_tag_i),
    .evict_valid_i(evict_valid_i), .evict_dirty_i(evict_dirty_i), .evict_tag_i(evict_tag_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_dirty_o(resp_dirty_o),
    .lookup_tag_o(lookup_tag_o), .tag_hit_i(tag_hit_i), .tag_hit_way_i(tag_hit_way_i),
    .tag_valid_vec_i(tag_valid_vec_i), .rd_dirty_i(rd_dirty_i),
    .tag_we_o(tag_we_o), .tag_way_o(tag_way_o),
    .wr_valid_o(wr_valid_o), .wr_dirty_o(wr_dirty_o), .wr_tag_o(wr_tag_o),
    .mem_wb_valid_o(mem_wb_valid_o), .mem_wb_ready_i(mem_wb_ready_i), .mem_wb_tag_o(mem_wb_tag_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- tag array environment (written only by the DUT) ----------------
  logic [7:0]    env_valid = '0;
  logic [7:0]    env_dirty = '0;
  logic [TW-1:0] env_tag [8];

  always @(posedge clk) begin
    if (tag_we_o) begin
      env_valid[tag_way_o] <= wr_valid_o;
      env_dirty[tag_way_o] <= wr_dirty_o;
      env_tag[tag_way_o]   <= wr_tag_o;
    end
  end

  always_comb begin
    tag_hit_i     = 1'b0;
    tag_hit_way_i = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (env_valid[i] && env_tag[i] == lookup_tag_o) begin
        tag_hit_i     = 1'b1;
        tag_hit_way_i = 3'(i);
      end
    end
  end
  assign tag_valid_vec_i = env_valid;
  assign rd_dirty_i      = env_dirty[tag_way_o];

  // ---------------- reference model and scoreboard queues ----------------
  bit            m_valid [8];
  bit            m_dirty [8];
  logic [TW-1:0] m_tag [8];
  int            m_rr = 0;

  logic [32:0] exp_wr_q[$];    // {way, valid, dirty, tag}
  logic [35:0] exp_wb_q[$];    // {wait cycles, tag}
  logic [9:0]  exp_resp_q[$];  // {hit, dirty, response cycle}
  int          acc_q[$];

  task automatic predict(input logic [TW-1:0] rt, input logic ev_v, input logic ev_d,
                         input logic [TW-1:0] et, input int wt);
    int hw = -1;
    int fw = -1;
    int way;
    int lat;
    for (int i = 0; i < 8; i++) if (hw < 0 && m_valid[i] && m_tag[i] == rt) hw = i;
    if (hw >= 0) begin
      exp_resp_q.push_back({1'b1, m_dirty[hw], 8'd3});
      exp_wr_q.push_back({3'(hw), ev_v, ev_v & ev_d, et});
      m_valid[hw] = ev_v;
      m_dirty[hw] = ev_v & ev_d;
      m_tag[hw]   = et;
    end else if (!ev_v) begin
      exp_resp_q.push_back({1'b0, 1'b0, 8'd2});
    end else begin
      for (int i = 0; i < 8; i++) if (fw < 0 && !m_valid[i]) fw = i;
      lat = 3;
      if (fw >= 0) begin
        way = fw;
      end else begin
        way = m_rr;
        if (m_dirty[way]) begin
          exp_wb_q.push_back({8'(wt), m_tag[way]});
          lat = 4 + wt;
        end
        m_rr = (m_rr + 1) % 8;
      end
      exp_wr_q.push_back({3'(way), 1'b1, ev_d, et});
      m_valid[way] = 1'b1;
      m_dirty[way] = ev_d;
      m_tag[way]   = et;
      exp_resp_q.push_back({1'b0, 1'b0, 8'(lat)});
    end
  endtask

  function automatic logic [TW-1:0] fresh(input logic [TW-1:0] excl);
    logic [TW-1:0] t;
    bit clash;
    do begin
      t = TW'(32'h1000 + $urandom_range(0, 255));
      clash = (t == excl);
      for (int i = 0; i < 8; i++) if (m_valid[i] && m_tag[i] == t) clash = 1'b1;
    end while (clash);
    return t;
  endfunction

  task automatic flush_all();
    exp_wr_q.delete();
    exp_wb_q.delete();
    exp_resp_q.delete();
    acc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  int wb_wait_cur = 0;

  task automatic drive_req(input logic [TW-1:0] rt, input logic ev_v, input logic ev_d,
                           input logic [TW-1:0] et);
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready_o), 64'd1);
    req_valid_i   = 1'b1;
    req_tag_i     = rt;
    evict_valid_i = ev_v;
    evict_dirty_i = ev_d;
    evict_tag_i   = et;
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_resp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("resp_timeout", 64'(exp_resp_q.size()), 64'd0);
    if (exp_resp_q.size() != 0) flush_all();
  endtask

  task automatic issue(input logic [TW-1:0] rt, input logic ev_v, input logic ev_d,
                       input logic [TW-1:0] et, input int wt);
    predict(rt, ev_v, ev_d, et, wt);
    drive_req(rt, ev_v, ev_d, et);
    wait_done();
  endtask

  task automatic evict_only_miss(input logic ev_d, input int wt);
    logic [TW-1:0] rt;
    rt = fresh('0);
    issue(rt, 1'b1, ev_d, fresh(rt), wt);
  endtask

  // ---------------- monitor: scoreboard pops, plus memory ready responder ----------------
  int          wb_cnt = 0;
  logic [35:0] mw;
  logic [32:0] mwr;
  logic [9:0]  mr;
  int          ma;

  always @(negedge clk) begin
    if (!rst_ni) begin
      mem_wb_ready_i = 1'b0;
      wb_cnt = 0;
    end else begin
      if (mem_wb_valid_o) begin
        if (exp_wb_q.size() == 0) begin
          chk("wb_unexpected", 64'd1, 64'd0);
          mem_wb_ready_i = 1'b1;
        end else begin
          mw = exp_wb_q[0];
          chk("wb_tag", 64'(mem_wb_tag_o), 64'(mw[27:0]));
          wb_cnt++;
          if (wb_cnt == int'(mw[35:28]) + 1) begin
            mem_wb_ready_i = 1'b1;
            void'(exp_wb_q.pop_front());
            wb_cnt = 0;
          end else begin
            mem_wb_ready_i = 1'b0;
          end
        end
      end else begin
        if (wb_cnt != 0) chk("wb_dropped_early", 64'(wb_cnt), 64'd0);
        mem_wb_ready_i = 1'b0;
        wb_cnt = 0;
      end
      if (tag_we_o) begin
        if (exp_wr_q.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          mwr = exp_wr_q.pop_front();
          chk("wr_way", 64'(tag_way_o), 64'(mwr[32:30]));
          chk("wr_valid", 64'(wr_valid_o), 64'(mwr[29]));
          chk("wr_dirty", 64'(wr_dirty_o), 64'(mwr[28]));
          if (mwr[29]) chk("wr_tag", 64'(wr_tag_o), 64'(mwr[27:0]));
        end
      end
      if (resp_valid_o) begin
        if (exp_resp_q.size() == 0 || acc_q.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          mr = exp_resp_q.pop_front();
          ma = acc_q.pop_front();
          chk("resp_hit", 64'(resp_hit_o), 64'(mr[9]));
          chk("resp_dirty", 64'(resp_dirty_o), 64'(mr[8]));
          chk("resp_cycle", 64'(cyc - ma + 1), 64'(mr[7:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit            sv_valid [8];
  bit            sv_dirty [8];
  logic [TW-1:0] sv_tag [8];

  initial begin
    logic [TW-1:0] rt;
    logic [TW-1:0] et;
    int n;
    bit found;
    int w;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_hit", 64'(resp_hit_o), 64'd0);
    chk("rst_resp_dirty", 64'(resp_dirty_o), 64'd0);
    chk("rst_tag_we", 64'(tag_we_o), 64'd0);
    chk("rst_mem_wb_valid", 64'(mem_wb_valid_o), 64'd0);
    chk("rst_tag_way", 64'(tag_way_o), 64'd0);
    chk("rst_wr_fields", 64'({wr_valid_o, wr_dirty_o, wr_tag_o}), 64'd0);
    chk("rst_mem_wb_tag", 64'(mem_wb_tag_o), 64'd0);
    chk("rst_lookup_tag", 64'(lookup_tag_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Empty array: miss inserts the clean evicted line into way 0.
    issue(28'h100, 1'b1, 1'b0, 28'h200, 0);
    // Hit without an evicted line invalidates the hit way.
    issue(28'h200, 1'b0, 1'b0, 28'h0, 0);
    chk("inval_way0_valid", 64'(env_valid[0]), 64'd0);
    // Reinsert 0x200 dirty, then hit it while swapping in clean 0x300.
    issue(28'h101, 1'b1, 1'b1, 28'h200, 0);
    issue(28'h200, 1'b1, 1'b0, 28'h300, 0);
    // Miss with no evicted line.
    issue(28'h555, 1'b0, 1'b0, 28'h0, 0);

    // Fill the remaining ways clean, then 9 full misses walk 0..7 and wrap to 0.
    for (int k = 0; k < 7; k++) evict_only_miss(1'b0, 0);
    for (int k = 0; k < 9; k++) evict_only_miss(1'b0, 0);

    // Make way 3 hold dirty 0x0AB, move the pointer to 3, then force a stalled writeback.
    issue(m_tag[3], 1'b0, 1'b0, 28'h0, 0);
    chk("inval_way3_valid", 64'(env_valid[3]), 64'd0);
    issue(fresh('0), 1'b1, 1'b1, 28'h0AB, 0);
    evict_only_miss(1'b0, 0);
    evict_only_miss(1'b0, 0);
    chk("model_rr_at_3", 64'(m_rr), 64'd3);
    evict_only_miss(1'b0, 4);

    // Randomized traffic mixing hits, swaps, invalidates, inserts and writebacks.
    for (int k = 0; k < 150; k++) begin
      found = 1'b0;
      rt = '0;
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 16; j++) begin
          w = $urandom_range(0, 7);
          if (!found && m_valid[w]) begin
            rt = m_tag[w];
            found = 1'b1;
          end
        end
      end
      if (!found) rt = fresh('0);
      et = fresh(rt);
      issue(rt, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), et, $urandom_range(0, 3));
    end

    // Reset while waiting in writeback: fill with dirty lines and aim the pointer at a dirty way.
    for (int k = 0; k < 8; k++) begin
      found = 1'b1;
      for (int i = 0; i < 8; i++) if (!m_valid[i]) found = 1'b0;
      if (!found) evict_only_miss(1'b1, 0);
    end
    for (int k = 0; k < 8; k++) if (!m_dirty[m_rr]) evict_only_miss(1'b1, 0);
    sv_valid = m_valid;
    sv_dirty = m_dirty;
    sv_tag   = m_tag;
    rt = fresh('0);
    et = fresh(rt);
    predict(rt, 1'b1, 1'b0, et, 10);
    drive_req(rt, 1'b1, 1'b0, et);
    n = 0;
    while (!mem_wb_valid_o && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wb_before_reset", 64'(mem_wb_valid_o), 64'd1);
    @(negedge clk);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wb_valid_drop", 64'(mem_wb_valid_o), 64'd0);
    chk("rst_wb_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_wb_tag_we", 64'(tag_we_o), 64'd0);
    flush_all();
    m_valid = sv_valid;
    m_dirty = sv_dirty;
    m_tag   = sv_tag;
    m_rr    = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    // Pointer restarts at way 0 after reset.
    evict_only_miss(1'b0, 2);
    evict_only_miss(1'b1, 1);

    repeat (5) @(posedge clk);
    chk("leftover_wr", 64'(exp_wr_q.size()), 64'd0);
    chk("leftover_wb", 64'(exp_wb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
